hazard_sb: RTL and testbench
============================

HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers; register 0 is never tracked.
REQ-002 Parameter AW, default $clog2(NREG), register-index width.
REQ-003 Parameter MAX_LAT, default 3, maximum producer latency in cycles.
REQ-004 Parameter LW, default $clog2(MAX_LAT+1), latency/counter width.
REQ-005 Parameter NSTALL, default 3, number of long-stall request sources (e.g. instr, data, div).
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 resetn  in  1  asynchronous active-low reset.
REQ-009 valid_d  in  1  D-stage holds a real instruction.
REQ-010 rs_d, rt_d  in  AW each  D-stage source indices.
REQ-011 use_rs_d, use_rt_d  in  1 each  the source is actually read.
REQ-012 branch_d  in  1  D-stage branch or jr, resolved in D.
REQ-013 wen_d, wreg_d  in  1, AW  D instruction writes wreg_d.
REQ-014 lat_d  in  LW  cycles after leaving D until result is forwardable (ALU=1, load=2).
REQ-015 long_stall_req  in  NSTALL  any bit freezes the whole pipe.
REQ-016 except_m  in  1  exception in M; flush request.
REQ-017 stall_f, stall_d, stall_e, stall_m, stall_w  out  1 each  stage hold.
REQ-018 flush_f, flush_d, flush_e, flush_m, flush_w  out  1 each  stage bubble.
REQ-019 longest_stall  out  1  OR of long_stall_req.
REQ-020 stall_cnt  out  32  saturating count of cycles with stall_d=1.

Function
REQ-021 Per-register scoreboard counter cnt[r] (LW bits, r=1..NREG-1); 0 means value forwardable now.
REQ-022 Freeze = longest_stall & ~except_m; on freeze, all cnt hold.
REQ-023 Otherwise, each cycle, every nonzero cnt decrements by 1.
REQ-024 Issue = valid_d & wen_d & wreg_d!=0 & lat_d!=0 & ~stall_d & ~except_m; on issue, cnt[wreg_d] loads min(lat_d, MAX_LAT), overriding that register's decrement.
REQ-025 Source hazard (rs and rt alike): use & idx!=0 & (branch_d ? cnt[idx]!=0 : cnt[idx]>1).
REQ-026 dep_stall = valid_d & (hazard_rs | hazard_rt).
REQ-027 stall_d = dep_stall | longest_stall; stall_f = stall_d & ~except_m.
REQ-028 stall_e = stall_m = longest_stall; stall_w = longest_stall & ~except_m.
REQ-029 flush_e = (dep_stall & ~longest_stall) | except_m; flush_f = flush_d = flush_m = flush_w = except_m.
REQ-030 except_m clears all cnt to 0 on the same edge, with priority over freeze and issue.
REQ-031 stall_cnt increments when stall_d=1, saturates at 32'hFFFF_FFFF, and holds otherwise.
REQ-032 All outputs are combinational from state and inputs; zero-cycle latency from input to stall/flush.

Reset
REQ-033 resetn low: all cnt and stall_cnt clear to 0 immediately; with valid_d=0, long_stall_req=0 and except_m=0, every output is 0.
REQ-034 A reset asserted mid-stall discards all pending counts; the first cycle after release has no dependency stall.

Structure
REQ-035 Shared package holds the default parameters and the latency constants LAT_ALU=1 and LAT_LOAD=2.
REQ-036 One sub-module, hazard_sb_entry (one counter with load/decrement/clear/hold), instantiated NREG-1 times.

Verification
REQ-037 Load r5 (lat 2) issues, then add reading r5 in D -> stall_d=1 and flush_e=1 for exactly 1 cycle, then proceeds.
REQ-038 ALU writes r7 (lat 1), then beq reading r7 -> 1-cycle stall; with lat 2 -> 2-cycle stall.
REQ-039 long_stall_req=3'b100 for 4 cycles while cnt[5]=2 -> cnt[5] stays 2, flush_e=0, and stall_d..stall_w are 1.
REQ-040 except_m=1 while cnt[5]=2 and long_stall_req=1 -> all flushes 1, stall_f=0, stall_w=0; next cycle cnt=0.
REQ-041 rs_d=0 with cnt untouched, and a write to r0 -> no stall; back-to-back issues to r9 (lat 2 then 1) -> newest value (1) is kept.
REQ-042 stall_cnt preset near 32'hFFFF_FFFE with 3 stall cycles -> ends at 32'hFFFF_FFFF without wrapping.

Source files
------------

// File: rtl/hazard_sb_pkg.sv
// Shared defaults and producer latency constants
// for the D-stage hazard scoreboard.
package hazard_sb_pkg;

  localparam int NREG_DEF    = 32;
  localparam int MAX_LAT_DEF = 3;
  localparam int NSTALL_DEF  = 3;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard counter: cycles until the
// register value becomes forwardable.
module hazard_sb_entry #(
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          hold,
  input  logic          load,
  input  logic [LW-1:0] loadVal,
  output logic [LW-1:0] cnt
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (load) begin
      cnt <= loadVal;
    end else if (cnt != '0) begin
      cnt <= cnt - LW'(1);
    end
  end

endmodule

// File: rtl/hazard_sb.sv
// D-stage hazard scoreboard: dependency stalls,
// global freeze and exception flush control.
module hazard_sb
  import hazard_sb_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int AW      = $clog2(NREG),
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int LW      = $clog2(MAX_LAT + 1),
  parameter int NSTALL  = NSTALL_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_d,
  input  logic [AW-1:0]     rs_d,
  input  logic [AW-1:0]     rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic              branch_d,
  input  logic              wen_d,
  input  logic [AW-1:0]     wreg_d,
  input  logic [LW-1:0]     lat_d,
  input  logic [NSTALL-1:0] long_stall_req,
  input  logic              except_m,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              stall_w,
  output logic              flush_f,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              longest_stall,
  output logic [31:0]       stall_cnt
);

  logic [LW-1:0] cnt [NREG];
  logic [LW-1:0] latClip;
  logic [LW:0]   latWide;
  logic          freeze;
  logic          issue;
  logic          hzRs;
  logic          hzRt;
  logic          depStall;
  logic [31:0]   stallCnt;

  assign cnt[0] = '0;

  assign longest_stall = |long_stall_req;
  assign freeze        = longest_stall & ~except_m;

  // Branches compare in D, so they need the value
  // now; others can take it off the bypass next cycle.
  assign hzRs = use_rs_d && (rs_d != '0) &&
                (branch_d ? (cnt[rs_d] != '0)
                          : (cnt[rs_d] > LW'(1)));
  assign hzRt = use_rt_d && (rt_d != '0) &&
                (branch_d ? (cnt[rt_d] != '0)
                          : (cnt[rt_d] > LW'(1)));

  assign depStall = valid_d & (hzRs | hzRt);

  assign stall_d = depStall | longest_stall;
  assign stall_f = stall_d & ~except_m;
  assign stall_e = longest_stall;
  assign stall_m = longest_stall;
  assign stall_w = longest_stall & ~except_m;

  assign flush_e = (depStall & ~longest_stall) | except_m;
  assign flush_f = except_m;
  assign flush_d = except_m;
  assign flush_m = except_m;
  assign flush_w = except_m;

  assign latWide = {1'b0, lat_d};
  assign latClip = (latWide > (LW + 1)'(MAX_LAT)) ?
                   LW'(MAX_LAT) : lat_d;

  assign issue = valid_d & wen_d & (wreg_d != '0) &
                 (lat_d != '0) & ~stall_d & ~except_m;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    hazard_sb_entry #(
      .LW(LW)
    ) u_ent (
      .clk    (clk),
      .resetn (resetn),
      .clr    (except_m),
      .hold   (freeze),
      .load   (issue && (wreg_d == AW'(r))),
      .loadVal(latClip),
      .cnt    (cnt[r])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stallCnt <= '0;
    end else if (stall_d && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_sb.sv
// Directed and random checks of hazard_sb against
// a cycle-level scoreboard model.
module tb_hazard_sb;
  import hazard_sb_pkg::*;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int LW   = 2;
  localparam int MAXL = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          valid_d;
  logic [AW-1:0] rs_d, rt_d, wreg_d;
  logic          use_rs_d, use_rt_d;
  logic          branch_d, wen_d;
  logic [LW-1:0] lat_d;
  logic [2:0]    long_stall_req;
  logic          except_m;
  logic          stall_f, stall_d, stall_e;
  logic          stall_m, stall_w;
  logic          flush_f, flush_d, flush_e;
  logic          flush_m, flush_w;
  logic          longest_stall;
  logic [31:0]   stall_cnt;

  int          total = 0;
  int          bad   = 0;
  int          mc [NREG];
  logic [31:0] msc;
  logic        expSd;

  hazard_sb u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .valid_d       (valid_d),
    .rs_d          (rs_d),
    .rt_d          (rt_d),
    .use_rs_d      (use_rs_d),
    .use_rt_d      (use_rt_d),
    .branch_d      (branch_d),
    .wen_d         (wen_d),
    .wreg_d        (wreg_d),
    .lat_d         (lat_d),
    .long_stall_req(long_stall_req),
    .except_m      (except_m),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .stall_e       (stall_e),
    .stall_m       (stall_m),
    .stall_w       (stall_w),
    .flush_f       (flush_f),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .flush_m       (flush_m),
    .flush_w       (flush_w),
    .longest_stall (longest_stall),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic hz(input int idx,
                              input logic u);
    if (!u || idx == 0) return 1'b0;
    if (branch_d) return mc[idx] != 0;
    return mc[idx] > 1;
  endfunction

  function automatic logic [10:0] expOuts();
    logic ls, dep, ex;
    ls  = |long_stall_req;
    ex  = except_m;
    dep = valid_d & (hz(int'(rs_d), use_rs_d) |
                     hz(int'(rt_d), use_rt_d));
    return {(dep | ls) & ~ex, dep | ls, ls, ls,
            ls & ~ex, ex, ex, (dep & ~ls) | ex,
            ex, ex, ls};
  endfunction

  function automatic logic [10:0] gotOuts();
    return {stall_f, stall_d, stall_e, stall_m,
            stall_w, flush_f, flush_d, flush_e,
            flush_m, flush_w, longest_stall};
  endfunction

  task automatic clrModel();
    for (int i = 0; i < NREG; i++) mc[i] = 0;
    msc = '0;
  endtask

  task automatic idle();
    valid_d = 0; rs_d = '0; rt_d = '0;
    use_rs_d = 0; use_rt_d = 0; branch_d = 0;
    wen_d = 0; wreg_d = '0; lat_d = '0;
    long_stall_req = '0; except_m = 0;
  endtask

  // Inputs are set just after a falling edge.
  task automatic step(input string tag);
    logic [10:0] e;
    logic issue;
    int l;
    #1;
    if (!resetn) clrModel();
    e = expOuts();
    expSd = e[9];
    chk({tag, "_outs"}, 64'(gotOuts()), 64'(e));
    chk({tag, "_scnt"}, 64'(stall_cnt), 64'(msc));
    issue = valid_d & wen_d & (wreg_d != 0) &
            (lat_d != 0) & ~expSd & ~except_m;
    l = (int'(lat_d) > MAXL) ? MAXL : int'(lat_d);
    @(posedge clk);
    if (!resetn) begin
      clrModel();
    end else begin
      if (expSd && msc != 32'hFFFF_FFFF) msc++;
      if (except_m) begin
        for (int i = 0; i < NREG; i++) mc[i] = 0;
      end else if (|long_stall_req) begin
      end else begin
        for (int i = 1; i < NREG; i++)
          if (mc[i] > 0) mc[i]--;
        if (issue) mc[int'(wreg_d)] = l;
      end
    end
    @(negedge clk);
  endtask

  task automatic issueTo(input int r, input int l);
    idle();
    valid_d = 1; wen_d = 1;
    wreg_d = AW'(r); lat_d = LW'(l);
    step("iss");
  endtask

  // Branch on r: stall cycles before it proceeds.
  task automatic brStall(input string tag,
                         input int r,
                         input int exp);
    int n = 0;
    idle();
    valid_d = 1; branch_d = 1;
    use_rs_d = 1; rs_d = AW'(r);
    for (int k = 0; k < 6; k++) begin
      #1;
      if (!stall_d) break;
      n++;
      step(tag);
    end
    chk(tag, 64'(n), 64'(exp));
    step({tag, "_go"});
  endtask

  initial begin
    clrModel();
    idle();
    resetn = 0;
    #2;
    chk("rst_outs", 64'(gotOuts()), 64'd0);
    chk("rst_scnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    step("rst");
    resetn = 1;
    step("idle");

    // load-use: one bubble, then proceeds
    issueTo(5, LAT_LOAD);
    idle();
    valid_d = 1; use_rs_d = 1; rs_d = 5'd5;
    wen_d = 1; wreg_d = 5'd6; lat_d = 2'd1;
    #1;
    chk("ldu_sd", 64'(stall_d), 64'd1);
    chk("ldu_fe", 64'(flush_e), 64'd1);
    step("ldu1");
    #1;
    chk("ldu_go", 64'(stall_d), 64'd0);
    step("ldu2");

    // branch needs the value in D itself
    issueTo(7, LAT_ALU);
    brStall("br_lat1", 7, 1);
    issueTo(7, LAT_LOAD);
    brStall("br_lat2", 7, 2);

    // long stall freezes pending counts
    issueTo(5, LAT_LOAD);
    idle();
    long_stall_req = 3'b100;
    valid_d = 1; use_rs_d = 1; rs_d = 5'd5;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("frz_fe", 64'(flush_e), 64'd0);
      chk("frz_st", 64'({stall_d, stall_e,
                         stall_m, stall_w}), 64'hF);
      step("frz");
      chk("frz_c5", 64'(u_dut.cnt[5]), 64'd2);
    end

    // exception during freeze wins
    long_stall_req = 3'b001;
    except_m = 1;
    #1;
    chk("exc_fl", 64'({flush_f, flush_d, flush_e,
                       flush_m, flush_w}), 64'h1F);
    chk("exc_sf", 64'(stall_f), 64'd0);
    chk("exc_sw", 64'(stall_w), 64'd0);
    step("exc");
    chk("exc_c5", 64'(u_dut.cnt[5]), 64'd0);

    // r0 never tracked; newest r9 write wins
    issueTo(0, LAT_LOAD);
    idle();
    valid_d = 1; use_rs_d = 1; use_rt_d = 1;
    #1;
    chk("r0_sd", 64'(stall_d), 64'd0);
    step("r0");
    issueTo(9, 2);
    issueTo(9, 1);
    chk("r9_new", 64'(u_dut.cnt[9]), 64'd1);
    idle();
    step("r9");

    // async reset mid-stall drops pending counts
    issueTo(12, 3);
    idle();
    long_stall_req = 3'b010;
    step("pre_rst");
    #2;
    resetn = 0;
    #1;
    chk("arst_c12", 64'(u_dut.cnt[12]), 64'd0);
    chk("arst_sc", 64'(stall_cnt), 64'd0);
    clrModel();
    @(negedge clk);
    resetn = 1;
    idle();
    valid_d = 1; use_rs_d = 1; rs_d = 5'd12;
    branch_d = 1;
    #1;
    chk("arst_sd", 64'(stall_d), 64'd0);
    step("post_rst");

    // stall counter saturation
    idle();
    force u_dut.stallCnt = 32'hFFFF_FFFE;
    release u_dut.stallCnt;
    msc = 32'hFFFF_FFFE;
    long_stall_req = 3'b001;
    for (int k = 0; k < 3; k++) step("sat");
    chk("sat_end", 64'(stall_cnt), 64'hFFFF_FFFF);
    idle();
    resetn = 0;
    step("sat_rst");
    resetn = 1;

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      valid_d  = $urandom_range(0, 3) != 0;
      rs_d     = AW'($urandom_range(0, 15));
      rt_d     = AW'($urandom_range(0, 15));
      use_rs_d = $urandom_range(0, 1) == 1;
      use_rt_d = $urandom_range(0, 1) == 1;
      branch_d = $urandom_range(0, 3) == 0;
      wen_d    = $urandom_range(0, 3) != 0;
      wreg_d   = AW'($urandom_range(0, 15));
      lat_d    = LW'($urandom_range(0, 3));
      long_stall_req = ($urandom_range(0, 7) == 0) ?
        3'($urandom_range(1, 7)) : 3'b000;
      except_m = $urandom_range(0, 19) == 0;
      resetn   = $urandom_range(0, 99) != 0;
      step("rnd");
      resetn = 1;
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
